hls_deadlock_axis_probe: RTL and testbench
==========================================

// Module: hls_deadlock_axis_probe
// PURPOSE
//   Source side of the HLS deadlock-monitor chain. Watches the valid/ready
//   handshake of NUM_CH AXI-stream channels around an HLS instance and raises
//   a per-channel axis_block_sigs bit once a channel has stalled for
//   STALL_THRESH consecutive cycles. Feeds the deadlock monitor tree.
//   Latches a sticky first-block report (channel, stall kind, timestamp) for debug readout.
// PARAMETERS
//   NUM_CH        2    number of monitored stream channels (1..16)
//   CNT_W         8    stall counter width; counter saturates at 2^CNT_W-1
//   STALL_THRESH  16   consecutive stall cycles before block asserts (1..2^CNT_W-1)
//   TS_W          32   free-running timestamp width
// PORTS
//   clock            in   1          single clock, rising edge
//   reset            in   1          asynchronous, active-high
//   enable           in   1          1 = monitoring active
//   clear            in   1          1-cycle pulse; clears sticky report
//   chan_valid       in   NUM_CH     per-channel TVALID
//   chan_ready       in   NUM_CH     per-channel TREADY
//   axis_block_sigs  out  NUM_CH     per-channel blocked flag to deadlock monitor
//   report_valid     out  1          sticky: a block has been captured
//   report_chan      out  clog2(NUM_CH) (min 1)  index of captured channel
//   report_kind      out  1          0 = full stall (valid&!ready), 1 = empty stall (ready&!valid)
//   report_time      out  TS_W       timestamp at capture edge
// BEHAVIOUR
//   Reset: all outputs 0, all counters 0, all channel FSMs IDLE, timestamp 0.
//   Timestamp: +1 every edge out of reset regardless of enable; wraps mod 2^TS_W.
//   Per-channel condition sampled each edge: XFER (v&r), FULL (v&!r),
//     EMPTY (!v&r), NONE (!v&!r).
//   Per-channel FSM: IDLE, STALL_FULL, STALL_EMPTY, BLOCKED.
//     XFER or NONE   -> IDLE, cnt<=0.
//     FULL  from IDLE/STALL_EMPTY -> STALL_FULL, cnt<=1; EMPTY symmetric.
//     same stall kind again -> cnt<=cnt+1 (saturating); when new cnt
//       >= STALL_THRESH -> BLOCKED (kind retained), block bit 1.
//     BLOCKED: same kind holds BLOCKED, cnt keeps saturating count;
//       opposite stall kind -> other STALL state, cnt<=1, block 0;
//       XFER/NONE -> IDLE, block 0.
//   Latency: block is registered; rises after the edge sampling the
//     STALL_THRESH-th consecutive stall cycle, falls after first edge that
//     samples a non-matching condition. STALL_THRESH=1 -> block one cycle after stall.
//   enable=0: all FSMs forced IDLE, cnt 0, block bits 0 on next edge; report
//     registers hold. Re-enable starts counting fresh.
//   Report capture: on an edge where report_valid=0 (or clear=1) and any
//     channel enters BLOCKED, capture lowest-index such channel, its kind,
//     and the current timestamp value; report_valid<=1. Later blocks ignored.
//   clear with no new entry that edge -> report_valid<=0, other fields hold.
//     clear and a new entry on the same edge -> new capture wins.
//   Reset mid-stall: everything returns to reset values immediately (async).
// TESTING
//   T1 NUM_CH=2, THRESH=4: ch0 v=1,r=0 for 6 cycles -> block[0] high after
//      4th stall edge, report_chan=0, kind=0, report_time=timestamp at that edge.
//   T2 ch1 r=1,v=0 for 3 cycles then v=1 -> no block, cnt back to 0, no report.
//   T3 ch0 FULL 3 cycles, EMPTY 4 cycles -> block[0] only after 4th EMPTY,
//      kind=1 (kind switch restarts count).
//   T4 both channels start FULL same cycle -> both block bits rise together,
//      report_chan=0; clear then ch1 stays blocked -> no recapture (not entering).
//   T5 ch0 blocked, deassert enable -> block[0]=0 next cycle, report holds;
//      re-enable with stall continuing -> block again after THRESH edges.
//   T6 assert reset asynchronously mid-block -> all outputs 0 before next
//      edge; CNT_W=3, THRESH=7, 20-cycle stall -> cnt saturates at 7, block steady.

Source files
------------

// File: rtl/hls_deadlock_axis_probe.sv
// AXI-stream stall probe: flags channels stuck in one stall kind for STALL_THRESH cycles
// and latches a sticky report of the first channel to block.
module hls_deadlock_axis_probe #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 8,
    parameter int STALL_THRESH = 16,
    parameter int TS_W         = 32,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [NUM_CH-1:0] chan_valid,
    input  logic [NUM_CH-1:0] chan_ready,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              report_valid,
    output logic [CH_W-1:0]   report_chan,
    output logic              report_kind,
    output logic [TS_W-1:0]   report_time
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STALL_FULL  = 2'd1,
        STALL_EMPTY = 2'd2,
        BLOCKED     = 2'd3
    } chan_state_e;

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

    chan_state_e       state_q [NUM_CH];
    chan_state_e       state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] kind_q;
    logic [NUM_CH-1:0] kind_d;
    logic [NUM_CH-1:0] entering;
    logic [TS_W-1:0]   ts_q;

    logic              stall_kind;
    logic              same_kind;
    logic [CNT_W-1:0]  cnt_new;
    logic              any_enter;
    logic [CH_W-1:0]   enter_idx;
    logic              enter_kind;

    // Kind bit: 0 = producer waiting on consumer (full), 1 = consumer starved (empty).
    always_comb begin
        stall_kind = 1'b0;
        same_kind  = 1'b0;
        cnt_new    = '0;
        entering   = '0;
        kind_d     = kind_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            if (enable && (chan_valid[i] != chan_ready[i])) begin
                stall_kind = chan_ready[i];
                same_kind  = ((state_q[i] == STALL_FULL)  && !stall_kind) ||
                             ((state_q[i] == STALL_EMPTY) &&  stall_kind) ||
                             ((state_q[i] == BLOCKED)     && (kind_q[i] == stall_kind));
                if (!same_kind)
                    cnt_new = CNT_ONE;
                else if (cnt_q[i] == CNT_MAX)
                    cnt_new = cnt_q[i];
                else
                    cnt_new = cnt_q[i] + CNT_ONE;
                cnt_d[i]  = cnt_new;
                kind_d[i] = stall_kind;
                if (cnt_new >= THRESH)
                    state_d[i] = BLOCKED;
                else
                    state_d[i] = stall_kind ? STALL_EMPTY : STALL_FULL;
                entering[i] = (state_d[i] == BLOCKED) && (state_q[i] != BLOCKED);
            end
        end
    end

    // Lowest-index channel wins when several block on the same edge.
    always_comb begin
        any_enter  = |entering;
        enter_idx  = '0;
        enter_kind = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (entering[i]) begin
                enter_idx  = CH_W'(i);
                enter_kind = kind_d[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            kind_q          <= '0;
            axis_block_sigs <= '0;
            ts_q            <= '0;
            report_valid    <= 1'b0;
            report_chan     <= '0;
            report_kind     <= 1'b0;
            report_time     <= '0;
        end else begin
            ts_q   <= ts_q + TS_ONE;
            kind_q <= kind_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]         <= state_d[i];
                cnt_q[i]           <= cnt_d[i];
                axis_block_sigs[i] <= (state_d[i] == BLOCKED);
            end
            if ((!report_valid || clear) && any_enter) begin
                report_valid <= 1'b1;
                report_chan  <= enter_idx;
                report_kind  <= enter_kind;
                report_time  <= ts_q;
            end else if (clear) begin
                report_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hls_deadlock_axis_probe.sv
// Scoreboard bench for hls_deadlock_axis_probe: run-length reference model feeds a queue
// that a free-running monitor drains one entry per clock edge.
module tb_hls_deadlock_axis_probe;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 3;
    localparam int THRESH = 4;
    localparam int TS_W   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic [NUM_CH-1:0] chan_valid = '0;
    logic [NUM_CH-1:0] chan_ready = '0;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic              report_valid;
    logic [0:0]        report_chan;
    logic              report_kind;
    logic [TS_W-1:0]   report_time;

    hls_deadlock_axis_probe #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STALL_THRESH(THRESH), .TS_W(TS_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .chan_valid(chan_valid), .chan_ready(chan_ready),
        .axis_block_sigs(axis_block_sigs), .report_valid(report_valid),
        .report_chan(report_chan), .report_kind(report_kind), .report_time(report_time)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NUM_CH-1:0] blk;
        logic              rv;
        logic              rc;
        logic              rk;
        logic [TS_W-1:0]   rt;
    } exp_t;

    exp_t  sbQueue[$];
    int    vectorCount = 0;
    int    missCount = 0;
    string phaseName = "reset";

    int              runLen [NUM_CH];
    logic            runKind [NUM_CH];
    logic [NUM_CH-1:0] mBlk;
    logic            mRv, mRc, mRk;
    logic [TS_W-1:0] mRt, mTs;

    function automatic exp_t modelSnapshot();
        exp_t e;
        e.blk = mBlk; e.rv = mRv; e.rc = mRc; e.rk = mRk; e.rt = mRt;
        return e;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            runLen[i] = 0;
            runKind[i] = 1'b0;
        end
        mBlk = '0; mRv = 1'b0; mRc = 1'b0; mRk = 1'b0; mRt = '0; mTs = '0;
    endtask

    // A channel is blocked once its current same-kind stall run reaches THRESH cycles.
    task automatic modelEdge(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                             input logic en, input logic clr);
        logic [NUM_CH-1:0] newBlk;
        int first;
        first = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!en || (v[i] == r[i])) begin
                runLen[i] = 0;
            end else if (runLen[i] > 0 && runKind[i] == r[i]) begin
                runLen[i] = runLen[i] + 1;
            end else begin
                runLen[i] = 1;
                runKind[i] = r[i];
            end
            newBlk[i] = (runLen[i] >= THRESH);
        end
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (newBlk[i] && !mBlk[i]) first = i;
        if ((!mRv || clr) && first >= 0) begin
            mRv = 1'b1;
            mRc = first[0];
            mRk = runKind[first];
            mRt = mTs;
        end else if (clr) begin
            mRv = 1'b0;
        end
        mBlk = newBlk;
        mTs  = mTs + 1'b1;
    endtask

    task automatic checkOutput(input string name, input exp_t exp);
        exp_t act;
        act.blk = axis_block_sigs; act.rv = report_valid; act.rc = report_chan;
        act.rk = report_kind; act.rt = report_time;
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s @%0t: got blk=%b rv=%b ch=%0d kind=%b time=%0d, want blk=%b rv=%b ch=%0d kind=%b time=%0d",
                     name, $time, act.blk, act.rv, act.rc, act.rk, act.rt,
                     exp.blk, exp.rv, exp.rc, exp.rk, exp.rt);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                                 input logic en, input logic clr);
        @(posedge clock);
        #2;
        reset = 1'b0;
        chan_valid = v; chan_ready = r; enable = en; clear = clr;
        modelEdge(v, r, en, clr);
        sbQueue.push_back(modelSnapshot());
    endtask

    // Reset lands between edges; outputs must already be zero before the next edge.
    task automatic pulseReset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset", modelSnapshot());
        sbQueue.push_back(modelSnapshot());
    endtask

    task automatic repeatStim(input int n, input logic [NUM_CH-1:0] v,
                              input logic [NUM_CH-1:0] r, input logic en);
        for (int k = 0; k < n; k++) applyStimulus(v, r, en, 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sbQueue.size() > 0) checkOutput(phaseName, sbQueue.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int holdLeft [NUM_CH];
        int mode [NUM_CH];
        logic [NUM_CH-1:0] v, r;
        modelReset();
        @(posedge clock);
        @(posedge clock);
        #2;
        checkOutput("reset_state", modelSnapshot());

        phaseName = "t1_full_block";
        repeatStim(6, 2'b01, 2'b00, 1'b1);
        repeatStim(2, 2'b00, 2'b00, 1'b1);

        phaseName = "t2_empty_short";
        repeatStim(3, 2'b00, 2'b10, 1'b1);
        repeatStim(2, 2'b10, 2'b10, 1'b1);

        phaseName = "t3_kind_switch";
        repeatStim(3, 2'b01, 2'b00, 1'b1);
        repeatStim(4, 2'b00, 2'b01, 1'b1);
        repeatStim(1, 2'b00, 2'b00, 1'b1);

        phaseName = "t4_both_full";
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1);
        repeatStim(5, 2'b11, 2'b00, 1'b1);
        applyStimulus(2'b11, 2'b01, 1'b1, 1'b1);
        repeatStim(2, 2'b11, 2'b01, 1'b1);

        phaseName = "t5_enable_drop";
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1);
        repeatStim(5, 2'b01, 2'b00, 1'b1);
        repeatStim(2, 2'b01, 2'b00, 1'b0);
        repeatStim(5, 2'b01, 2'b00, 1'b1);

        phaseName = "t6_saturate_reset";
        repeatStim(20, 2'b01, 2'b00, 1'b1);
        pulseReset();
        repeatStim(5, 2'b00, 2'b11, 1'b1);

        phaseName = "random";
        for (int i = 0; i < NUM_CH; i++) holdLeft[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (holdLeft[i] == 0) begin
                    mode[i] = $urandom_range(0, 3);
                    holdLeft[i] = $urandom_range(1, 9);
                end
                holdLeft[i]--;
                v[i] = (mode[i] == 0) || (mode[i] == 1);
                r[i] = (mode[i] == 0) || (mode[i] == 2);
            end
            if ($urandom_range(0, 199) == 0)
                pulseReset();
            else
                applyStimulus(v, r, $urandom_range(0, 29) != 0, $urandom_range(0, 14) == 0);
        end

        phaseName = "drain";
        repeatStim(2, 2'b00, 2'b00, 1'b1);
        @(posedge clock);
        #3;
        vectorCount++;
        if (sbQueue.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sbQueue.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
